// File: rtl/pixel_stream_ctrl.sv
// pixel_stream_ctrl: streams one frame of pixels from the image RAM to the GPIO pins.
// Reads go out in linear address order. Each read waits out the RAM latency.
// Each pixel is then held on the pins until the consumer acks it.
module pixel_stream_ctrl #(
  parameter int IMG_W   = 400,
  parameter int IMG_H   = 400,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] gpio_data,
  output logic              gpio_valid,
  input  logic              gpio_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_count
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt, addr_cnt_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              launch;  // start accepted in IDLE
  logic              take;    // presented pixel acked and not aborted

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, next address and handshake decode; abort wins over every other event.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state;
    addr_cnt_nxt = addr_cnt;
    launch       = 1'b0;
    take         = 1'b0;
    unique case (state)
      S_IDLE: begin
        addr_cnt_nxt = '0;
        if (start && !abort) begin
          state_nxt = S_FETCH;
          launch    = 1'b1;
        end
      end
      S_FETCH: begin
        state_nxt = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort)                    state_nxt = S_IDLE;
        else if (lat_cnt == LAT_LAST) state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (gpio_ack) begin
          take = 1'b1;
          if (addr_cnt == LAST_ADDR) begin
            state_nxt = S_DONE;
          end else begin
            addr_cnt_nxt = addr_cnt + 1'b1;
            state_nxt    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and counters, all derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt   <= '0;
      lat_cnt    <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      gpio_data  <= '0;
      gpio_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_count  <= '0;
    end else begin
      addr_cnt <= addr_cnt_nxt;
      lat_cnt  <= (state == S_WAIT && state_nxt == S_WAIT) ? lat_cnt + 1'b1 : '0;

      mem_rd <= (state_nxt == S_FETCH);
      if (state_nxt == S_FETCH) mem_addr <= addr_cnt_nxt;

      // Capture RAM data on the last WAIT edge, hold it through PRESENT, zero it otherwise.
      gpio_valid <= (state_nxt == S_PRESENT);
      if (state_nxt != S_PRESENT) gpio_data <= '0;
      else if (state == S_WAIT)   gpio_data <= mem_rdata;

      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);

      if (launch)    pix_count <= '0;
      else if (take) pix_count <= pix_count + 1'b1;
    end
  end

endmodule
